// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
// Program counter and fetch stage. PC_o addresses the program ROM
// combinationally. The ROM word returned in the same cycle is captured together
// with its PC into the fetch register, which feeds decode/execute. The unit
// advances sequentially, accepts branch/jump redirects, and honours stalls. It
// halts when the PC leaves the program image.
//
// Ports
//   clk                  in   1   rising-edge clock
//   reset                in   1   synchronous, active-high reset
//   Stall_i              in   1   hold PC and fetch register this cycle
//   Redirect_i           in   1   taken branch / JAL / JALR this cycle
//   Redirect_Target_i    in   32  byte target address for the redirect
//   Instruction_i        in   32  ROM data for the current PC_o
//   PC_o                 out  32  current PC (ROM byte address)
//   Fetch_PC_o           out  32  PC of the instruction in the fetch register
//   Fetch_PC_Plus4_o     out  32  Fetch_PC_o + 4 (link value)
//   Fetch_Instruction_o  out  32  registered instruction word
//   Fetch_Valid_o        out  1   fetch register holds a real instruction
//   Misaligned_o         out  1   one-cycle pulse for an unaligned redirect target
//   Halted_o             out  1   unit is in the HALT state
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0040_0000,
    parameter int          MEMORY_DEPTH = 32,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall_i,
    input  logic        Redirect_i,
    input  logic [31:0] Redirect_Target_i,
    input  logic [31:0] Instruction_i,
    output logic [31:0] PC_o,
    output logic [31:0] Fetch_PC_o,
    output logic [31:0] Fetch_PC_Plus4_o,
    output logic [31:0] Fetch_Instruction_o,
    output logic        Fetch_Valid_o,
    output logic        Misaligned_o,
    output logic        Halted_o
);

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } state_t;

    // First byte address past the program image (32-bit wrapping arithmetic).
    localparam logic [31:0] WINDOW_END = RESET_PC + 32'(4 * MEMORY_DEPTH);

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] fetch_pc_r;
    logic [31:0] fetch_instr_r;
    logic        fetch_valid_r;
    logic        misaligned_r;
    logic        halted_r;

    logic [31:0] target_aligned_s;
    logic        target_in_window_s;
    logic        pc_in_window_s;

    // True when a byte address lies inside the program image.
    function automatic logic in_window(input logic [31:0] addr);
        return (addr >= RESET_PC) && (addr < WINDOW_END);
    endfunction

    // Redirect target is forced to a word boundary. Window checks use the aligned value.
    always_comb begin
        target_aligned_s   = {Redirect_Target_i[31:2], 2'b00};
        target_in_window_s = in_window(target_aligned_s);
        pc_in_window_s     = in_window(pc_r);
    end

    // PC, fetch register and FSM. Priority order: reset, redirect, stall, advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_FETCH;
            pc_r          <= RESET_PC;
            fetch_pc_r    <= 32'h0000_0000;
            fetch_instr_r <= NOP_INSTR;
            fetch_valid_r <= 1'b0;
            misaligned_r  <= 1'b0;
            halted_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (Redirect_i) begin
                        // Flush: the word fetched at the old PC is wrong-path.
                        pc_r          <= target_aligned_s;
                        fetch_instr_r <= NOP_INSTR;
                        fetch_valid_r <= 1'b0;
                        misaligned_r  <= |Redirect_Target_i[1:0];
                    end else if (Stall_i) begin
                        misaligned_r  <= 1'b0;
                    end else if (pc_in_window_s) begin
                        fetch_instr_r <= Instruction_i;
                        fetch_pc_r    <= pc_r;
                        fetch_valid_r <= 1'b1;
                        pc_r          <= pc_r + 32'd4;
                        misaligned_r  <= 1'b0;
                    end else begin
                        // Ran off the image: park with a bubble in the fetch register.
                        state_r       <= ST_HALT;
                        halted_r      <= 1'b1;
                        fetch_instr_r <= NOP_INSTR;
                        fetch_valid_r <= 1'b0;
                        misaligned_r  <= 1'b0;
                    end
                end
                ST_HALT: begin
                    if (Redirect_i) begin
                        pc_r          <= target_aligned_s;
                        fetch_instr_r <= NOP_INSTR;
                        fetch_valid_r <= 1'b0;
                        misaligned_r  <= |Redirect_Target_i[1:0];
                        if (target_in_window_s) begin
                            state_r  <= ST_FETCH;
                            halted_r <= 1'b0;
                        end else begin
                            state_r  <= ST_HALT;
                            halted_r <= 1'b1;
                        end
                    end else begin
                        // Stall has no effect while halted.
                        fetch_valid_r <= 1'b0;
                        misaligned_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r       <= ST_FETCH;
                    pc_r          <= RESET_PC;
                    fetch_instr_r <= NOP_INSTR;
                    fetch_valid_r <= 1'b0;
                    misaligned_r  <= 1'b0;
                    halted_r      <= 1'b0;
                end
            endcase
        end
    end

    assign PC_o                = pc_r;
    assign Fetch_PC_o          = fetch_pc_r;
    assign Fetch_PC_Plus4_o    = fetch_pc_r + 32'd4;
    assign Fetch_Instruction_o = fetch_instr_r;
    assign Fetch_Valid_o       = fetch_valid_r;
    assign Misaligned_o        = misaligned_r;
    assign Halted_o            = halted_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Directed bench for instruction_fetch_unit. A behavioural ROM returns
// 0x1000_0000 + word index inside the program image. Outside the image it
// returns 0xDEAD_BEEF.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    localparam logic [31:0] BASE = 32'h0040_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        Stall_i;
    logic        Redirect_i;
    logic [31:0] Redirect_Target_i;
    logic [31:0] Instruction_i;
    logic [31:0] PC_o;
    logic [31:0] Fetch_PC_o;
    logic [31:0] Fetch_PC_Plus4_o;
    logic [31:0] Fetch_Instruction_o;
    logic        Fetch_Valid_o;
    logic        Misaligned_o;
    logic        Halted_o;

    int errors = 0;
    int checks = 0;

    instruction_fetch_unit dut (
        .clk                 (clk),
        .reset               (reset),
        .Stall_i             (Stall_i),
        .Redirect_i          (Redirect_i),
        .Redirect_Target_i   (Redirect_Target_i),
        .Instruction_i       (Instruction_i),
        .PC_o                (PC_o),
        .Fetch_PC_o          (Fetch_PC_o),
        .Fetch_PC_Plus4_o    (Fetch_PC_Plus4_o),
        .Fetch_Instruction_o (Fetch_Instruction_o),
        .Fetch_Valid_o       (Fetch_Valid_o),
        .Misaligned_o        (Misaligned_o),
        .Halted_o            (Halted_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural program ROM.
    logic [31:0] rom_off;
    assign rom_off       = PC_o - BASE;
    assign Instruction_i = (PC_o >= BASE && rom_off < 32'd128)
                           ? (32'h1000_0000 + (rom_off >> 2)) : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks every fetch-side output against expected values.
    task automatic check_fetch(input string tag, input logic [31:0] pc,
                               input logic [31:0] fpc, input logic [31:0] instr,
                               input logic valid);
        check({tag, "_pc"},    PC_o, pc);
        check({tag, "_fpc"},   Fetch_PC_o, fpc);
        check({tag, "_fpc4"},  Fetch_PC_Plus4_o, fpc + 32'd4);
        check({tag, "_instr"}, Fetch_Instruction_o, instr);
        check({tag, "_valid"}, {31'd0, Fetch_Valid_o}, {31'd0, valid});
    endtask

    initial begin
        reset = 1'b1; Stall_i = 1'b0; Redirect_i = 1'b0; Redirect_Target_i = 32'h0;

        // T1: reset for two cycles
        step(); step();
        check_fetch("rst", BASE, 32'h0, NOP, 1'b0);
        check("rst_halt", {31'd0, Halted_o}, 32'd0);
        check("rst_mis",  {31'd0, Misaligned_o}, 32'd0);
        reset = 1'b0;

        // T1/T2: sequential fetch of words 0..4
        for (int i = 0; i < 5; i++) begin
            step();
            check_fetch($sformatf("seq%0d", i), BASE + 32'(4 * (i + 1)),
                        BASE + 32'(4 * i), 32'h1000_0000 + 32'(i), 1'b1);
        end

        // T3: stall holds everything for 3 cycles
        Stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_fetch($sformatf("stall%0d", i), 32'h0040_0014, 32'h0040_0010,
                        32'h1000_0004, 1'b1);
        end
        // Redirect wins over stall
        Redirect_i = 1'b1; Redirect_Target_i = 32'h0040_0010;
        step();
        check_fetch("stred", 32'h0040_0010, 32'h0040_0010, NOP, 1'b0);
        check("stred_mis", {31'd0, Misaligned_o}, 32'd0);
        Stall_i = 1'b0; Redirect_i = 1'b0;
        step();
        check_fetch("stred_next", 32'h0040_0014, 32'h0040_0010, 32'h1000_0004, 1'b1);

        // T4: misaligned redirect pulses Misaligned_o for one cycle
        Redirect_i = 1'b1; Redirect_Target_i = 32'h0040_0006;
        step();
        check_fetch("mis", 32'h0040_0004, 32'h0040_0010, NOP, 1'b0);
        check("mis_pulse", {31'd0, Misaligned_o}, 32'd1);
        Redirect_i = 1'b0;
        step();
        check("mis_clear", {31'd0, Misaligned_o}, 32'd0);
        check_fetch("mis_next", 32'h0040_0008, 32'h0040_0004, 32'h1000_0001, 1'b1);

        // T5: run through word 31 (last word in the image)
        for (int i = 0; i < 30; i++) step();
        check_fetch("last", 32'h0040_0080, 32'h0040_007C, 32'h1000_001F, 1'b1);
        check("last_halt", {31'd0, Halted_o}, 32'd0);
        step();
        check_fetch("halt", 32'h0040_0080, 32'h0040_007C, NOP, 1'b0);
        check("halt_flag", {31'd0, Halted_o}, 32'd1);
        Stall_i = 1'b1;
        step();
        check_fetch("halt_st", 32'h0040_0080, 32'h0040_007C, NOP, 1'b0);
        check("halt_st_flag", {31'd0, Halted_o}, 32'd1);
        Stall_i = 1'b0;
        // Out-of-range redirect while halted: PC moves, stays halted
        Redirect_i = 1'b1; Redirect_Target_i = 32'h0050_0000;
        step();
        check("halt_oor_pc", PC_o, 32'h0050_0000);
        check("halt_oor_flag", {31'd0, Halted_o}, 32'd1);
        // In-range redirect resumes fetch
        Redirect_Target_i = BASE;
        step();
        check_fetch("resume", BASE, 32'h0040_007C, NOP, 1'b0);
        check("resume_flag", {31'd0, Halted_o}, 32'd0);
        Redirect_i = 1'b0;
        step();
        check_fetch("resume_next", 32'h0040_0004, BASE, 32'h1000_0000, 1'b1);

        // T6: reset beats a misaligned redirect on the same edge
        reset = 1'b1; Redirect_i = 1'b1; Redirect_Target_i = 32'h0040_0007;
        step();
        check_fetch("rstred", BASE, 32'h0, NOP, 1'b0);
        check("rstred_halt", {31'd0, Halted_o}, 32'd0);
        check("rstred_mis",  {31'd0, Misaligned_o}, 32'd0);
        reset = 1'b0; Redirect_i = 1'b0;
        step();
        check_fetch("rstred_next", 32'h0040_0004, BASE, 32'h1000_0000, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
